// File: rtl/dmem_arbiter_if.sv
// Shared data-memory / I-O bus bundle between the CPU memory stage, the
// DMA/debug loader and the memory unit, as seen by dmem_arbiter.
interface dmem_arbiter_if #(
  parameter int DBITS = 32
);
  logic             cpuReq;
  logic             cpuWe;
  logic [DBITS-1:0] cpuAddr;
  logic [DBITS-1:0] cpuWdata;
  logic             cpuStall;
  logic [DBITS-1:0] cpuRdata;
  logic             cpuRvalid;

  logic             dmaReq;
  logic             dmaWe;
  logic [DBITS-1:0] dmaAddr;
  logic [DBITS-1:0] dmaWdata;
  logic             dmaGnt;
  logic [DBITS-1:0] dmaRdata;
  logic             dmaRvalid;

  logic [DBITS-1:0] memAddr;
  logic             memWe;
  logic [DBITS-1:0] memWdata;
  logic [DBITS-1:0] memRdata;

  // The arbiter side.
  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata,
    input  dmaReq, dmaWe, dmaAddr, dmaWdata,
    input  memRdata,
    output cpuStall, cpuRdata, cpuRvalid,
    output dmaGnt, dmaRdata, dmaRvalid,
    output memAddr, memWe, memWdata
  );

  // The surrounding system: requesters plus the memory unit.
  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata,
    output dmaReq, dmaWe, dmaAddr, dmaWdata,
    output memRdata,
    input  cpuStall, cpuRdata, cpuRvalid,
    input  dmaGnt, dmaRdata, dmaRvalid,
    input  memAddr, memWe, memWdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the data-memory/I-O bus: CPU memory stage has priority,
// the DMA loader wins after MAX_WAIT consecutive losses. One access in flight.
module dmem_arbiter #(
  parameter int DBITS    = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_BITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CPU_RD = 2'd1;
  localparam logic [1:0] DMA_RD = 2'd2;

  localparam logic [CNT_BITS-1:0] STARVE_MAX = CNT_BITS'(MAX_WAIT);

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [CNT_BITS-1:0] starve;
  logic [CNT_BITS-1:0] next_starve;
  logic [DBITS-1:0]    rd_addr;
  logic                idle;
  logic                cpu_win;
  logic                dma_win;

  // Reset forces every output quiet in the reset cycle itself, so it gates
  // the current state rather than only the next one.
  assign idle = (state == IDLE) && !reset;

  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (idle) begin
      if (bus.dmaReq && (starve == STARVE_MAX)) dma_win = 1'b1;
      else if (bus.cpuReq)                      cpu_win = 1'b1;
      else if (bus.dmaReq)                      dma_win = 1'b1;
    end
  end

  always_comb begin
    bus.memAddr   = '0;
    bus.memWe     = 1'b0;
    bus.memWdata  = '0;
    bus.cpuStall  = 1'b0;
    bus.cpuRdata  = '0;
    bus.cpuRvalid = 1'b0;
    bus.dmaGnt    = 1'b0;
    bus.dmaRdata  = '0;
    bus.dmaRvalid = 1'b0;
    if (idle) begin
      bus.cpuStall = bus.cpuReq && !(cpu_win && bus.cpuWe);
      if (cpu_win) begin
        bus.memAddr  = bus.cpuAddr;
        bus.memWe    = bus.cpuWe;
        bus.memWdata = bus.cpuWdata;
      end else if (dma_win) begin
        bus.memAddr  = bus.dmaAddr;
        bus.memWe    = bus.dmaWe;
        bus.memWdata = bus.dmaWdata;
        bus.dmaGnt   = 1'b1;
      end
    end else if (!reset && (state == CPU_RD)) begin
      bus.memAddr   = rd_addr;
      bus.cpuRvalid = 1'b1;
      bus.cpuRdata  = bus.memRdata;
    end else if (!reset && (state == DMA_RD)) begin
      bus.memAddr   = rd_addr;
      bus.dmaRvalid = 1'b1;
      bus.dmaRdata  = bus.memRdata;
      bus.cpuStall  = bus.cpuReq;
    end
  end

  // Writes finish in their issue cycle; only reads occupy a second cycle.
  always_comb begin
    next_state = IDLE;
    if (state == IDLE) begin
      if (cpu_win && !bus.cpuWe)      next_state = CPU_RD;
      else if (dma_win && !bus.dmaWe) next_state = DMA_RD;
    end
  end

  always_comb begin
    next_starve = starve;
    if (state == IDLE) begin
      if (dma_win || !bus.dmaReq)
        next_starve = '0;
      else if (cpu_win && (starve != STARVE_MAX))
        next_starve = starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      starve  <= '0;
      rd_addr <= '0;
    end else begin
      state  <= next_state;
      starve <= next_starve;
      if (cpu_win && !bus.cpuWe)
        rd_addr <= bus.cpuAddr;
      else if (dma_win && !bus.dmaWe)
        rd_addr <= bus.dmaAddr;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed cycle-by-cycle vectors for dmem_arbiter, plus hand-built sequences
// for DMA withdrawal and starvation-forced DMA grants.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        reset;
    logic        cpuReq;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWdata;
    logic        dmaReq;
    logic        dmaWe;
    logic [31:0] dmaAddr;
    logic [31:0] dmaWdata;
    logic [31:0] memRdata;
  } in_t;

  typedef struct packed {
    logic        cpuStall;
    logic        cpuRvalid;
    logic [31:0] cpuRdata;
    logic        dmaGnt;
    logic        dmaRvalid;
    logic [31:0] dmaRdata;
    logic [31:0] memAddr;
    logic        memWe;
    logic [31:0] memWdata;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  logic clk;
  logic reset;
  int   applied;
  int   miscompares;
  vec_t vecs[$];

  dmem_arbiter_if #(.DBITS(32)) bus();

  dmem_arbiter #(.DBITS(32), .MAX_WAIT(8), .CNT_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input in_t s);
    reset        = s.reset;
    bus.cpuReq   = s.cpuReq;
    bus.cpuWe    = s.cpuWe;
    bus.cpuAddr  = s.cpuAddr;
    bus.cpuWdata = s.cpuWdata;
    bus.dmaReq   = s.dmaReq;
    bus.dmaWe    = s.dmaWe;
    bus.dmaAddr  = s.dmaAddr;
    bus.dmaWdata = s.dmaWdata;
    bus.memRdata = s.memRdata;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t got;
    got = '{bus.cpuStall, bus.cpuRvalid, bus.cpuRdata, bus.dmaGnt, bus.dmaRvalid,
            bus.dmaRdata, bus.memAddr, bus.memWe, bus.memWdata};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic runCycle(input string name, input in_t s, input out_t exp);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t mkIn(input logic rst, input logic cr, input logic cw,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd,
                               input logic [31:0] mr);
    mkIn = '{rst, cr, cw, ca, cd, dr, dw, da, dd, mr};
  endfunction

  function automatic out_t mkOut(input logic st, input logic crv, input logic [31:0] crd,
                                 input logic dg, input logic drv, input logic [31:0] drd,
                                 input logic [31:0] ma, input logic mw,
                                 input logic [31:0] md);
    mkOut = '{st, crv, crd, dg, drv, drd, ma, mw, md};
  endfunction

  task automatic addVec(input string name, input in_t s, input out_t e);
    vec_t v;
    v.name = name;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  initial begin
    in_t  s;
    out_t e;
    applied     = 0;
    miscompares = 0;
    applyStimulus('0);
    reset = 1'b1;

    addVec("reset",        mkIn(1,0,0,0,0,0,0,0,0,0),
                           mkOut(0,0,0,0,0,0,0,0,0));
    addVec("idle",         mkIn(0,0,0,0,0,0,0,0,0,0),
                           mkOut(0,0,0,0,0,0,0,0,0));
    addVec("cpu_store",    mkIn(0,1,1,32'hF0000004,32'h3FF,0,0,0,0,0),
                           mkOut(0,0,0,0,0,0,32'hF0000004,1,32'h3FF));
    addVec("cpu_ld_issue", mkIn(0,1,0,32'h40,0,0,0,0,0,0),
                           mkOut(1,0,0,0,0,0,32'h40,0,0));
    addVec("cpu_ld_data",  mkIn(0,1,0,32'h40,0,0,0,0,0,32'h1234),
                           mkOut(0,1,32'h1234,0,0,0,32'h40,0,0));
    addVec("idle_after_ld",mkIn(0,0,0,0,0,0,0,0,0,32'h1234),
                           mkOut(0,0,0,0,0,0,0,0,0));
    addVec("dma_rd_issue", mkIn(0,0,0,0,0,1,0,32'h100,0,0),
                           mkOut(0,0,0,1,0,0,32'h100,0,0));
    addVec("dma_rd_data",  mkIn(0,1,0,32'h200,0,0,0,0,0,32'hABCD),
                           mkOut(1,0,0,0,1,32'hABCD,32'h100,0,0));
    addVec("cpu_after_dma",mkIn(0,1,0,32'h200,0,0,0,0,0,0),
                           mkOut(1,0,0,0,0,0,32'h200,0,0));
    addVec("cpu_ld2_data", mkIn(0,1,0,32'h200,0,0,0,0,0,32'h5555),
                           mkOut(0,1,32'h5555,0,0,0,32'h200,0,0));
    addVec("dma_write",    mkIn(0,0,0,0,0,1,1,32'h500,32'h77,0),
                           mkOut(0,0,0,1,0,0,32'h500,1,32'h77));
    addVec("ld_before_rst",mkIn(0,1,0,32'h40,0,0,0,0,0,0),
                           mkOut(1,0,0,0,0,0,32'h40,0,0));
    addVec("reset_mid_rd", mkIn(1,1,0,32'h40,0,0,0,0,0,32'h9999),
                           mkOut(0,0,0,0,0,0,0,0,0));
    addVec("ld_after_rst", mkIn(0,1,0,32'h40,0,0,0,0,0,0),
                           mkOut(1,0,0,0,0,0,32'h40,0,0));
    addVec("ld_rst_data",  mkIn(0,1,0,32'h40,0,0,0,0,0,32'h4242),
                           mkOut(0,1,32'h4242,0,0,0,32'h40,0,0));
    addVec("idle_end",     mkIn(0,0,0,0,0,0,0,0,0,0),
                           mkOut(0,0,0,0,0,0,0,0,0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) runCycle(vecs[i].name, vecs[i].stim, vecs[i].exp);

    // DMA requests for two cycles while CPU stores, then withdraws.
    for (int k = 0; k < 4; k++) begin
      s = mkIn(0,1,1,32'h10 + 32'(4*k),32'(k+1),(k < 2),1,32'h300,32'hAA,0);
      e = mkOut(0,0,0,0,0,0,32'h10 + 32'(4*k),1,32'(k+1));
      runCycle($sformatf("withdraw_%0d", k), s, e);
    end

    // Starvation: CPU wins 8 times, DMA forced on the 9th cycle, CPU again after.
    for (int k = 0; k < 10; k++) begin
      s = mkIn(0,1,1,32'h1000 + 32'(4*k),32'(k),1,1,32'h2000,32'hD0,0);
      if (k == 8)
        e = mkOut(1,0,0,1,0,0,32'h2000,1,32'hD0);
      else
        e = mkOut(0,0,0,0,0,0,32'h1000 + 32'(4*k),1,32'(k));
      runCycle($sformatf("starve_%0d", k), s, e);
    end

    runCycle("final_idle", mkIn(0,0,0,0,0,0,0,0,0,0), mkOut(0,0,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/I-O bus (data memory plus KEY/SW/HEX/LEDR/LEDG windows at 0xF0000000–0xF0000014) between the pipeline memory stage (CPU, port 0) and a DMA/debug loader (port 1).
- Sits between the pipeline register outputs and the memory unit.
- Issues at most one access at a time and stalls the pipeline while the CPU lacks the bus or awaits read data.
- A starvation counter guarantees the DMA port forward progress.

Parameters:
- DBITS, 32, data and address width.
- MAX_WAIT, 8, consecutive lost arbitration cycles after which DMA wins over CPU.
- CNT_BITS, 4, starvation counter width; must satisfy 2^CNT_BITS > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpuReq  in  1  CPU access request; held stable while cpuStall=1.
- cpuWe  in  1  1=store, 0=load.
- cpuAddr  in  DBITS  CPU byte address.
- cpuWdata  in  DBITS  CPU store data.
- cpuStall  out  1  freeze PC and pipeline register.
- cpuRdata  out  DBITS  load data, valid when cpuRvalid=1.
- cpuRvalid  out  1  one-cycle load-data strobe.
- dmaReq  in  1  DMA request; may be withdrawn before grant.
- dmaWe  in  1  1=write, 0=read.
- dmaAddr  in  DBITS  DMA byte address.
- dmaWdata  in  DBITS  DMA write data.
- dmaGnt  out  1  DMA access issued this cycle.
- dmaRdata  out  DBITS  DMA read data, valid when dmaRvalid=1.
- dmaRvalid  out  1  one-cycle read-data strobe.
- memAddr  out  DBITS  bus address.
- memWe  out  1  bus write enable.
- memWdata  out  DBITS  bus write data.
- memRdata  in  DBITS  bus read data; synchronous read, valid one cycle after address.

Behaviour:
- FSM states: IDLE, CPU_RD, DMA_RD. A new access may issue only in IDLE, so there is one outstanding access at most.
- Arbitration in IDLE, evaluated in priority order:
  1. dmaReq && starve==MAX_WAIT → DMA.
  2. cpuReq → CPU.
  3. dmaReq → DMA.
  4. Otherwise no grant.
- Issue cycle (combinational from the granted port's inputs): memAddr/memWe/memWdata are driven by the winner. With no grant, memAddr=0, memWe=0, memWdata=0. dmaGnt=1 only in a DMA issue cycle.
- Write issue: completes in the same cycle and the FSM stays in IDLE. Back-to-back writes are possible every cycle.
- Read issue: next state is CPU_RD or DMA_RD. In that state memWe=0, memAddr holds the issued address, memRdata is forwarded to the owner's rdata, and the owner's rvalid=1 for exactly that cycle. The FSM then returns to IDLE. Read throughput is one per 2 cycles.
- rdata outputs are 0 whenever their rvalid=0.
- cpuStall is combinational:
  - in IDLE: cpuStall = cpuReq && !(CPU granted && cpuWe);
  - in DMA_RD: cpuStall = cpuReq;
  - in CPU_RD: cpuStall = 0, and the load retires that cycle.
- Starvation counter `starve`, updated only in IDLE:
  - cleared on DMA grant or when dmaReq=0;
  - incremented when dmaReq=1 and the CPU is granted;
  - saturates at MAX_WAIT.
  - In CPU_RD/DMA_RD it holds.
- DMA port: dmaReq must be held until dmaGnt. Dropping it earlier withdraws the request with no side effects.
- Simultaneous requests with starve<MAX_WAIT: CPU wins and dmaGnt=0.
- Reset (any state, including mid-read): next cycle is IDLE with starve=0. No rvalid is emitted for the aborted read.
- Outputs during reset cycle and after: cpuStall=0, dmaGnt=0, cpuRvalid=0, dmaRvalid=0, memWe=0, memAddr=0, memWdata=0, rdata=0.

Test Plan:
- CPU store cpuAddr=0xF0000004, cpuWdata=0x3FF, no DMA → same cycle memWe=1, memAddr=0xF0000004, cpuStall=0; FSM stays IDLE.
- CPU load 0x40; memRdata=0x1234 one cycle later → issue cycle cpuStall=1; next cycle cpuRvalid=1, cpuRdata=0x1234, cpuStall=0; IDLE after.
- cpuReq and dmaReq (write) held continuously, CPU stores every cycle, MAX_WAIT=8 → CPU granted cycles 0–7; cycle 8 dmaGnt=1, cpuStall=1, starve→0; cycle 9 CPU granted again.
- DMA read 0x100 issued, CPU load requested next cycle → CPU stalled through DMA_RD; dmaRvalid=1 with memRdata; CPU load issues the following IDLE cycle.
- dmaReq pulsed 2 cycles during CPU stores then dropped → dmaGnt never asserts, starve returns to 0, memWe reflects only CPU.
- reset asserted in CPU_RD → cpuRvalid=0 that cycle; all outputs 0 and FSM IDLE the cycle after; a subsequent load completes normally.
